// File: rtl/fab_array_mult.sv
// fab_array_mult: sequential unsigned multiplier that reuses a single row of
// full-adder cells once per clock. W carry-save row passes accumulate the
// partial products. A final merge pass resolves the remaining sum/carry
// vectors into the upper half of the product.

// One full-adder cell: adds the partial-product bit x&y to the sum and carry
// coming in from the previous row pass.
module fab_cell (
  input  logic i_x,
  input  logic i_y,
  input  logic i_sin,
  input  logic i_cin,
  output logic o_sout,
  output logic o_cout
);

  logic w_pp;

  assign w_pp   = i_x & i_y;
  assign o_sout = w_pp ^ i_sin ^ i_cin;
  assign o_cout = (w_pp & i_sin) | (w_pp & i_cin) | (i_sin & i_cin);

endmodule

module fab_array_mult #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   product
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROW,
    ST_MERGE
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  // The sum bit of cell 0 is retired straight into PL every pass, so only
  // sum bits 1..W-1 need to be carried into the next row.
  logic [W-1:1]      r_s;
  logic [W-1:0]      r_c;
  logic [W-1:0]      r_pl;
  logic [IW-1:0]     r_row;
  logic              r_done;
  logic [2*W-1:0]    r_product;

  logic [W-1:0]      w_sin;
  logic [W-1:0]      w_sout;
  logic [W-1:0]      w_cout;
  logic              w_bit_b;
  logic              w_last_row;
  logic              w_accept;
  logic [W-1:0]      w_high;

  // The multiplier bit for the current row drives the y input of every cell.
  assign w_bit_b    = r_b[r_row];
  assign w_last_row = (r_row == IW'(W - 1));

  // A new request is taken in IDLE, and also on the merge edge so that
  // back-to-back operations run without a gap cycle.
  assign w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_MERGE));

  // Upper half: remaining sum bits (shifted by one position of weight) plus
  // the pending carries. Both vectors already sit at weight 2^W and above.
  assign w_high     = {1'b0, r_s} + r_c;

  // Cell row: cell j sees A[j], B[i], the sum from cell j+1 of the previous
  // pass (one weight lower after the row shift) and its own previous carry.
  genvar gj;
  generate
    for (gj = 0; gj < W; gj++) begin : g_cell
      if (gj == W - 1) begin : g_top
        assign w_sin[gj] = 1'b0;
      end else begin : g_inner
        assign w_sin[gj] = r_s[gj+1];
      end

      fab_cell u_cell (
        .i_x    (r_a[gj]),
        .i_y    (w_bit_b),
        .i_sin  (w_sin[gj]),
        .i_cin  (r_c[gj]),
        .o_sout (w_sout[gj]),
        .o_cout (w_cout[gj])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: W row passes followed by a single merge pass.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_ROW;
        end
      end
      ST_ROW: begin
        if (w_last_row) begin
          w_next_state = ST_MERGE;
        end
      end
      ST_MERGE: begin
        if (start) begin
          w_next_state = ST_ROW;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath: operand latch, carry-save accumulation and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_s       <= '0;
      r_c       <= '0;
      r_pl      <= '0;
      r_row     <= '0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= (r_state == ST_MERGE);

      if (r_state == ST_MERGE) begin
        r_product <= {w_high, r_pl};
      end

      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_s   <= '0;
        r_c   <= '0;
        r_pl  <= '0;
        r_row <= '0;
      end else if (r_state == ST_ROW) begin
        r_s         <= w_sout[W-1:1];
        r_c         <= w_cout;
        r_pl[r_row] <= w_sout[0];
        if (w_last_row) begin
          r_row <= '0;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_fab_array_mult.sv
// tb_fab_array_mult: randomized and directed checks of fab_array_mult at
// W=4 and W=8 against the plain arithmetic product a*b.
module tb_fab_array_mult;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        busy4;
  logic        done4;
  logic [7:0]  product4;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [15:0] product8;

  int compareCount  = 0;
  int mismatchCount = 0;

  fab_array_mult #(.W(4)) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start4),
    .a       (a4),
    .b       (b4),
    .busy    (busy4),
    .done    (done4),
    .product (product4)
  );

  fab_array_mult #(.W(8)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start8),
    .a       (a8),
    .b       (b8),
    .busy    (busy8),
    .done    (done8),
    .product (product8)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Guard against a run that never finishes.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for the next done pulse on the W=4 instance, counting edges.
  task automatic waitDone4(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (done4 !== 1'b1 && lat < 20);
  endtask

  // One complete W=4 operation with operands scrambled after acceptance.
  task automatic applyStimulus4(input logic [3:0] x, input logic [3:0] y, input string tag);
    int lat;
    int expProd;
    expProd = int'(x) * int'(y);
    @(negedge clk);
    a4 = x; b4 = y; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom);
    checkOutput({tag, " busy_after_E0"}, 32'(busy4), 32'd1);
    waitDone4(lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'd5);
    checkOutput({tag, " product"}, 32'(product4), 32'(expProd));
    checkOutput({tag, " busy_in_done"}, 32'(busy4), 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, " done_pulse"}, 32'(done4), 32'd0);
    checkOutput({tag, " product_hold"}, 32'(product4), 32'(expProd));
  endtask

  // One complete W=8 operation; latency must be 9 edges.
  task automatic applyStimulus8(input logic [7:0] x, input logic [7:0] y, input string tag);
    int lat;
    int expProd;
    expProd = int'(x) * int'(y);
    @(negedge clk);
    a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (done8 !== 1'b1 && lat < 30);
    checkOutput({tag, " latency"}, 32'(lat), 32'd9);
    checkOutput({tag, " product"}, 32'(product8), 32'(expProd));
  endtask

  initial begin
    int lat;
    int doneSeen;
    bit found;

    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst busy4", 32'(busy4), 32'd0);
    checkOutput("rst done4", 32'(done4), 32'd0);
    checkOutput("rst product4", 32'(product4), 32'd0);
    checkOutput("rst busy8", 32'(busy8), 32'd0);
    checkOutput("rst done8", 32'(done8), 32'd0);
    checkOutput("rst product8", 32'(product8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus4(4'd3, 4'd5, "basic");
    applyStimulus4(4'd15, 4'd15, "max4");

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        applyStimulus4(4'(x), 4'(y), "exh");
      end
    end

    // Back-to-back with start held high across three operations.
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd7; b4 = 4'd9;
    @(posedge clk); #1;
    a4 = 4'd0; b4 = 4'd12;
    waitDone4(lat);
    checkOutput("b2b1 gap", 32'(lat), 32'd5);
    checkOutput("b2b1 product", 32'(product4), 32'd63);
    checkOutput("b2b1 busy", 32'(busy4), 32'd1);
    a4 = 4'd15; b4 = 4'd1;
    waitDone4(lat);
    checkOutput("b2b2 gap", 32'(lat), 32'd5);
    checkOutput("b2b2 product", 32'(product4), 32'd0);
    checkOutput("b2b2 busy", 32'(busy4), 32'd1);
    start4 = 1'b0;
    waitDone4(lat);
    checkOutput("b2b3 gap", 32'(lat), 32'd5);
    checkOutput("b2b3 product", 32'(product4), 32'd15);
    checkOutput("b2b3 busy", 32'(busy4), 32'd0);
    doneSeen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done4) doneSeen++;
    end
    checkOutput("b2b extra_done", 32'(doneSeen), 32'd0);

    // A request pulsed while busy must be ignored, not queued.
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd6; b4 = 4'd7;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0; found = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      @(negedge clk);
      start4 = (k == 2 || k == 3);
      a4 = 4'd2; b4 = 4'd2;
      @(posedge clk); #1;
      if (done4) begin
        found = 1'b1;
        lat = k;
      end
    end
    start4 = 1'b0;
    checkOutput("ignore latency", 32'(lat), 32'd5);
    checkOutput("ignore product", 32'(product4), 32'd42);
    checkOutput("ignore busy", 32'(busy4), 32'd0);
    doneSeen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done4) doneSeen++;
    end
    checkOutput("ignore extra_done", 32'(doneSeen), 32'd0);
    checkOutput("ignore product_hold", 32'(product4), 32'd42);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd9;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busy4), 32'd0);
    checkOutput("abort done", 32'(done4), 32'd0);
    checkOutput("abort product", 32'(product4), 32'd0);
    doneSeen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done4) doneSeen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (done4) doneSeen++;
    end
    checkOutput("abort no_done", 32'(doneSeen), 32'd0);
    checkOutput("abort idle", 32'(busy4), 32'd0);
    applyStimulus4(4'd2, 4'd3, "after_rst");

    // Wider instance: corner cases then random operands.
    applyStimulus8(8'd255, 8'd255, "max8");
    applyStimulus8(8'd0, 8'd200, "zero8");
    applyStimulus8(8'd1, 8'd255, "one8");
    for (int n = 0; n < 1000; n++) begin
      applyStimulus8(8'($urandom), 8'($urandom), "rand8");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
